// File: rtl/arf132b192e1r1w0cbbehcaa4acw_wr_arb.sv
// Round-robin write-port arbiter and read-forwarding control for a 1R1W array.
// Ports: clk, rst (sync, active-low), req_valid/req_addr/req_data/req_ready
//   (per-requester handshake), wr_stall, wr_en/wr_addr/wr_data/wr_err
//   (registered array write), rd_en/rd_addr, fwd_hit/fwd_data.
module arf132b192e1r1w0cbbehcaa4acw_wr_arb #(
  parameter int NREQ   = 4,
  parameter int DEPTH  = 132,
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 192
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wr_stall,
  output logic                     wr_en,
  output logic [AWIDTH-1:0]        wr_addr,
  output logic [DWIDTH-1:0]        wr_data,
  output logic                     wr_err,
  input  logic                     rd_en,
  input  logic [AWIDTH-1:0]        rd_addr,
  output logic                     fwd_hit,
  output logic [DWIDTH-1:0]        fwd_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);

  logic [PW-1:0]     ptr_q, ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DWIDTH-1:0] wr_data_q, wr_data_d;
  logic              wr_err_q, wr_err_d;
  logic              fwd_hit_q, fwd_hit_d;
  logic [DWIDTH-1:0] fwd_data_q, fwd_data_d;

  logic              hi_vld, lo_vld, gnt_vld;
  logic [PW-1:0]     hi_idx, lo_idx, gnt_idx;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_data;
  logic              in_rng;
  logic              hit;

  // Round-robin search split in two passes: requesters at or above the
  // pointer win over those below it, giving the wrap-around order.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && (PW'(i) >= ptr_q) && !hi_vld) begin
        hi_vld = 1'b1;
        hi_idx = PW'(i);
      end
      if (req_valid[i] && (PW'(i) < ptr_q) && !lo_vld) begin
        lo_vld = 1'b1;
        lo_idx = PW'(i);
      end
    end
    gnt_idx = hi_vld ? hi_idx : lo_idx;
    gnt_vld = (hi_vld || lo_vld) && rst && !wr_stall;
  end

  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        req_ready[i] = gnt_vld;
        sel_addr     = req_addr[i*AWIDTH +: AWIDTH];
        sel_data     = req_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // Full-width compare; one extra bit keeps DEPTH == 2**AWIDTH correct.
  assign in_rng = ({1'b0, sel_addr} < DEPTH_W);

  // The array misses the write it performs in the same cycle as a read.
  assign hit = rd_en && wr_en_q && (rd_addr == wr_addr_q);

  always_comb begin
    ptr_d      = ptr_q;
    wr_en_d    = 1'b0;
    wr_err_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    fwd_hit_d  = hit;
    fwd_data_d = fwd_data_q;
    if (gnt_vld) begin
      ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
      if (in_rng) begin
        wr_en_d   = 1'b1;
        wr_addr_d = sel_addr;
        wr_data_d = sel_data;
      end else begin
        wr_err_d = 1'b1;
      end
    end
    if (hit) begin
      fwd_data_d = wr_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_err_q   <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_err_q   <= wr_err_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_err   = wr_err_q;
  assign fwd_hit  = fwd_hit_q;
  assign fwd_data = fwd_data_q;

endmodule

// File: tb/tb_arf132b192e1r1w0cbbehcaa4acw_wr_arb.sv
// Directed bench for the write-port arbiter and forwarding controller.
// Drives requesters, stall and read ports; checks grants and array writes.
module tb_arf132b192e1r1w0cbbehcaa4acw_wr_arb;

  localparam int NREQ   = 4;
  localparam int DEPTH  = 132;
  localparam int AWIDTH = 8;
  localparam int DWIDTH = 192;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*AWIDTH-1:0] req_addr;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   wr_stall;
  logic                   wr_en;
  logic [AWIDTH-1:0]      wr_addr;
  logic [DWIDTH-1:0]      wr_data;
  logic                   wr_err;
  logic                   rd_en;
  logic [AWIDTH-1:0]      rd_addr;
  logic                   fwd_hit;
  logic [DWIDTH-1:0]      fwd_data;

  int n_asrt;
  int n_fail;

  arf132b192e1r1w0cbbehcaa4acw_wr_arb #(
    .NREQ(NREQ), .DEPTH(DEPTH), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready),
    .wr_stall(wr_stall),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [DWIDTH-1:0] obs,
                     input logic [DWIDTH-1:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rdy(input string tag, input logic [NREQ-1:0] exp);
    #1;
    chk(tag, DWIDTH'(req_ready), DWIDTH'(exp));
  endtask

  task automatic wchk(input string tag, input logic en,
                      input logic [AWIDTH-1:0] a,
                      input logic [DWIDTH-1:0] d, input logic er);
    chk({tag, "_en"}, DWIDTH'(wr_en), DWIDTH'(en));
    chk({tag, "_addr"}, DWIDTH'(wr_addr), DWIDTH'(a));
    chk({tag, "_data"}, wr_data, d);
    chk({tag, "_err"}, DWIDTH'(wr_err), DWIDTH'(er));
  endtask

  task automatic setr(input int i, input logic v,
                      input logic [AWIDTH-1:0] a,
                      input logic [DWIDTH-1:0] d);
    req_valid[i] = v;
    req_addr[i*AWIDTH +: AWIDTH] = a;
    req_data[i*DWIDTH +: DWIDTH] = d;
  endtask

  initial begin
    n_asrt    = 0;
    n_fail    = 0;
    rst       = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    wr_stall  = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;

    // Reset: everything zero, no grant even with all valid.
    for (int i = 0; i < NREQ; i++) setr(i, 1'b1, AWIDTH'(i), DWIDTH'(i+1));
    step();
    step();
    wchk("rst", 1'b0, '0, '0, 1'b0);
    chk("rst_fhit", DWIDTH'(fwd_hit), '0);
    chk("rst_fdata", fwd_data, '0);
    rdy("rst_rdy", 4'b0000);

    // Release reset with all four valid: grants 0,1,2,3,0.
    rst = 1'b1;
    rdy("rr_g0", 4'b0001);
    step();
    wchk("rr_w0", 1'b1, 8'd0, 192'd1, 1'b0);
    rdy("rr_g1", 4'b0010);
    step();
    wchk("rr_w1", 1'b1, 8'd1, 192'd2, 1'b0);
    rdy("rr_g2", 4'b0100);
    step();
    wchk("rr_w2", 1'b1, 8'd2, 192'd3, 1'b0);
    rdy("rr_g3", 4'b1000);
    step();
    wchk("rr_w3", 1'b1, 8'd3, 192'd4, 1'b0);
    rdy("rr_g4", 4'b0001);
    step();
    wchk("rr_w4", 1'b1, 8'd0, 192'd1, 1'b0);
    rdy("rr_g5", 4'b0010);
    req_valid = '0;
    rdy("idle_rdy", 4'b0000);
    step();
    wchk("idle", 1'b0, 8'd0, 192'd1, 1'b0);

    // Requester 2 alone: last legal address, then first illegal one.
    setr(2, 1'b1, 8'd131, 192'h83);
    rdy("hi_rdy", 4'b0100);
    step();
    wchk("hi_w", 1'b1, 8'd131, 192'h83, 1'b0);
    setr(2, 1'b1, 8'd132, 192'hdead);
    rdy("oor_rdy", 4'b0100);
    step();
    wchk("oor_w", 1'b0, 8'd131, 192'h83, 1'b1);
    // Pointer must now be 3: requester 3 beats requester 0.
    setr(2, 1'b0, 8'd0, '0);
    setr(3, 1'b1, 8'd10, 192'h10);
    setr(0, 1'b1, 8'd20, 192'h20);
    rdy("ptr3_rdy", 4'b1000);
    step();
    wchk("ptr3_w", 1'b1, 8'd10, 192'h10, 1'b0);
    rdy("ptr0_rdy", 4'b0001);
    step();
    wchk("ptr0_w", 1'b1, 8'd20, 192'h20, 1'b0);
    req_valid = '0;
    step();
    chk("gap_en", DWIDTH'(wr_en), '0);

    // Stall with requesters 1 and 3 valid.
    setr(1, 1'b1, 8'd30, 192'h31);
    setr(3, 1'b1, 8'd40, 192'h41);
    wr_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rdy("stall_rdy", 4'b0000);
      step();
      chk("stall_en", DWIDTH'(wr_en), '0);
    end
    wr_stall = 1'b0;
    rdy("unst_g1", 4'b0010);
    step();
    wchk("unst_w1", 1'b1, 8'd30, 192'h31, 1'b0);
    rdy("unst_g3", 4'b1000);
    step();
    wchk("unst_w3", 1'b1, 8'd40, 192'h41, 1'b0);
    rdy("unst_g1b", 4'b0010);
    req_valid = '0;
    step();
    chk("unst_idle", DWIDTH'(wr_en), '0);

    // Forwarding: pointer is 0.
    setr(0, 1'b1, 8'd5, 192'ha5);
    rdy("fw_rdy", 4'b0001);
    step();
    wchk("fw_w", 1'b1, 8'd5, 192'ha5, 1'b0);
    req_valid = '0;
    rd_en   = 1'b1;
    rd_addr = 8'd5;
    step();
    chk("fw_hit", DWIDTH'(fwd_hit), 192'd1);
    chk("fw_data", fwd_data, 192'ha5);
    step();
    chk("fw_nowr", DWIDTH'(fwd_hit), '0);
    chk("fw_hold", fwd_data, 192'ha5);
    setr(1, 1'b1, 8'd6, 192'h66);
    rdy("fw6_rdy", 4'b0010);
    step();
    wchk("fw6_w", 1'b1, 8'd6, 192'h66, 1'b0);
    req_valid = '0;
    rd_addr = 8'd5;
    step();
    chk("fw_miss", DWIDTH'(fwd_hit), '0);
    chk("fw_miss_d", fwd_data, 192'ha5);
    setr(2, 1'b1, 8'd7, 192'h77);
    rdy("fw7_rdy", 4'b0100);
    step();
    req_valid = '0;
    rd_en   = 1'b0;
    rd_addr = 8'd7;
    step();
    chk("fw_nord", DWIDTH'(fwd_hit), '0);
    chk("fw_nord_d", fwd_data, 192'ha5);

    // Pointer is 3; requester 0 alone wins, then reset drops the write.
    setr(0, 1'b1, 8'd9, 192'h99);
    rdy("pre_rdy", 4'b0001);
    step();
    wchk("pre_w", 1'b1, 8'd9, 192'h99, 1'b0);
    rst = 1'b0;
    req_valid = 4'b1111;
    rdy("inrst_rdy", 4'b0000);
    step();
    wchk("post_rst", 1'b0, '0, '0, 1'b0);
    chk("post_fhit", DWIDTH'(fwd_hit), '0);
    chk("post_fdata", fwd_data, '0);
    rst = 1'b1;
    rdy("post_g0", 4'b0001);
    step();
    wchk("post_w0", 1'b1, 8'd9, 192'h99, 1'b0);
    rdy("post_g1", 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/arf132b192e1r1w0cbbehcaa4acw_wr_arb.md
# arf132b192e1r1w0cbbehcaa4acw_wr_arb

Write-port arbiter and read-forwarding controller for the 1-read/1-write register file array. It shares the array's single write port among NREQ requesters using round-robin arbitration with a valid/ready handshake, and issues one registered write per cycle to the array. It also flags and forwards same-cycle read/write address collisions so that consumers of the array read port see the latest data.

## Interface
- NREQ, 4, number of write requesters (2..8)
- DEPTH, 132, number of array entries; legal addresses are 0..DEPTH-1
- AWIDTH, 8, address width
- DWIDTH, 192, data width

- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset; one clock, reset is synchronous and active-low
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AWIDTH  per-requester address, requester i in bits [i*AWIDTH +: AWIDTH]
- req_data  in  NREQ*DWIDTH  per-requester data, packed the same way
- req_ready  out  NREQ  one-hot grant; a transfer occurs when valid[i]&ready[i]
- wr_stall  in  1  array cannot accept a write this cycle; no grants issued
- wr_en  out  1  registered array write enable
- wr_addr  out  AWIDTH  registered array write address
- wr_data  out  DWIDTH  registered array write data
- wr_err  out  1  one-cycle pulse: accepted request had an out-of-range address
- rd_en  in  1  array read issued this cycle
- rd_addr  in  AWIDTH  array read address
- fwd_hit  out  1  array read data of the previous cycle is stale; use fwd_data
- fwd_data  out  DWIDTH  forwarded write data, aligned with array read data

## Operation
- Round-robin pointer ptr (0..NREQ-1). Search order: ptr, ptr+1, ..., wrap mod NREQ. The first requester with req_valid high gets req_ready.
- req_ready is combinational from req_valid, ptr and wr_stall. It is all-zero when wr_stall=1 or rst=0.
- At most one bit of req_ready is high per cycle. It never asserts for a requester whose valid is low.
- On a transfer from requester g: ptr <= (g+1) mod NREQ. With no transfer, ptr holds.
- Accepted request with addr < DEPTH: next cycle wr_en=1, wr_addr/wr_data = accepted values.
- Accepted request with addr >= DEPTH: it is consumed (ready is given and ptr advances). Next cycle wr_en=0 and wr_err=1. wr_addr/wr_data hold their previous values.
- With no transfer: next cycle wr_en=0, wr_err=0. wr_addr/wr_data hold.
- Forwarding: the array read is synchronous; it returns data at t+1 and does not see the write performed in cycle t.
  - fwd_hit <= rd_en & wr_en & (rd_addr == wr_addr)
  - fwd_data <= wr_data when the hit condition is true; otherwise fwd_data holds.
- Address comparison is full AWIDTH width. There is no wrap of addresses.
- Reset (rst=0 at a posedge):
  - ptr=0, wr_en=0, wr_addr=0, wr_data=0, wr_err=0, fwd_hit=0, fwd_data=0.
  - A request accepted in the cycle before the reset edge is dropped; no write is issued after reset.

## Timing
- Grant to array write: 1 cycle. A request accepted at edge t produces wr_en high during cycle t+1.
- Throughput: one write per cycle when wr_stall=0. Back-to-back grants to the same requester are allowed only when no other requester is valid.
- Fairness: a continuously valid requester is granted within NREQ transfer cycles.
- wr_stall is sampled combinationally in the same cycle. A write already registered (wr_en high) completes regardless of wr_stall.
- Read forwarding latency: 1 cycle. fwd_hit and fwd_data are valid in the same cycle as the array read data.
- First cycle after rst deasserts: ptr=0, so requester 0 has highest priority.

## Test plan
- Reset release, all four requesters valid every cycle with addr=i, data=i+1 → grants 0,1,2,3,0 on consecutive cycles; wr_en=1 from the second cycle with wr_addr 0,1,2,3.
- Only requester 2 valid with addr=131, then addr=132 → first: wr_en=1, wr_addr=131 one cycle later. Second: ready=1, wr_en=0, wr_err=1 the next cycle, and ptr points to 3.
- Requesters 1 and 3 valid with wr_stall=1 for 3 cycles, then 0 → req_ready=0 during the stall; requester 1 is granted first after the stall, requester 3 next.
- Write in flight to addr 5 with data 0xA5 while rd_en=1, rd_addr=5 in the same cycle → next cycle fwd_hit=1 and fwd_data=0xA5. With rd_addr=6 instead → fwd_hit=0.
- Requester 0 accepted, then rst=0 on the next edge → wr_en=0 after reset, all outputs zero; post-reset grant starts at requester 0.
- Randomised valid patterns for NREQ=4, 10k cycles, checked against a scoreboard → req_ready is one-hot or zero, every accepted in-range request is written exactly once in order, and no requester waits more than 4 transfer cycles.
